// File: rtl/lut_load_pkg.sv
// Shared constants for the colour-correction LUT load sequencer.
// State codes are plain localparams to stay compatible with older tooling.
package lut_load_pkg;

  localparam int LUT_BYTES = 768;
  localparam int LUT_AW    = 10;

  localparam logic [LUT_AW-1:0] LUT_R_BASE = 10'd0;
  localparam logic [LUT_AW-1:0] LUT_G_BASE = 10'd256;
  localparam logic [LUT_AW-1:0] LUT_B_BASE = 10'd512;
  localparam logic [LUT_AW-1:0] LUT_LAST   = LUT_AW'(LUT_BYTES - 1);
  localparam logic [LUT_AW-1:0] LUT_END    = LUT_AW'(LUT_BYTES);

  typedef logic [1:0] lut_state_t;
  localparam lut_state_t IDLE     = 2'd0;
  localparam lut_state_t PREFETCH = 2'd1;
  localparam lut_state_t STREAM   = 2'd2;

  localparam int ERR_SOF_BIT = 0;
  localparam int ERR_WR_BIT  = 1;

endpackage

// File: rtl/lut_stage_ram.sv
// 768x8 simple dual-port staging RAM: one write port, one registered read
// port with a latency of one cycle.
module lut_stage_ram
  import lut_load_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [LUT_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [LUT_BYTES];

  // NOTE: RAM array and read register are deliberately left without reset so
  // they map onto block RAM; contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_load_ctrl.sv
// LUT load sequencer: stages R/G/B tables and replays them to color_correction
// during vertical blanking. Define LUT_LOAD_CHECKSUM_EN to add a checksum port.
module lut_load_ctrl
  import lut_load_pkg::*;
#(
  parameter int NROWS = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LUT_AW-1:0] cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic              commit,
  input  logic              err_clr,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              SOP,
  output logic              EOP,
  output logic              VLD,
  output logic [7:0]        packet_data,
`ifdef LUT_LOAD_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              busy,
  output logic              pending,
  output logic [1:0]        err
);

  localparam int LW = $clog2(NROWS + 1);

  lut_state_t        state;
  logic [LUT_AW-1:0] rd_cnt;
  logic              in_frame;
  logic [LW-1:0]     line_cnt;
  logic [7:0]        ram_q;

  logic sof, eol, idle, start, stream_done, ram_re;
  logic [1:0] err_set;

  assign sof         = s_axis_tvalid & s_axis_tuser;
  assign eol         = s_axis_tvalid & s_axis_tlast;
  assign idle        = (state == IDLE);
  // A commit arriving in the launch cycle is consumed directly; SOF always wins.
  assign start       = idle & (pending | commit) & ~in_frame & ~sof;
  assign stream_done = (state == STREAM) && (rd_cnt == LUT_END);
  assign ram_re      = (state == PREFETCH) | ((state == STREAM) & ~stream_done);
  assign busy        = ~idle;
  assign packet_data = VLD ? ram_q : 8'h00;

  always_comb begin
    err_set              = 2'b00;
    err_set[ERR_SOF_BIT] = sof & ~idle;
    err_set[ERR_WR_BIT]  = cfg_we & ~idle;
  end

  lut_stage_ram u_ram (
    .clk   (clk),
    .we    (cfg_we & idle),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .re    (ram_re),
    .raddr (rd_cnt),
    .rdata (ram_q)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame <= 1'b0;
      line_cnt <= '0;
    end else if (sof) begin
      in_frame <= 1'b1;
      line_cnt <= '0;
    end else if (eol && in_frame) begin
      if (line_cnt == LW'(NROWS - 1)) begin
        in_frame <= 1'b0;
        line_cnt <= '0;
      end else begin
        line_cnt <= line_cnt + LW'(1);
      end
    end
  end

  // Byte k leaves the RAM while address k+1 is being presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_cnt <= '0;
      SOP    <= 1'b0;
      EOP    <= 1'b0;
      VLD    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= PREFETCH;
            rd_cnt <= '0;
          end
        end
        PREFETCH: begin
          state  <= STREAM;
          rd_cnt <= LUT_AW'(1);
          VLD    <= 1'b1;
          SOP    <= 1'b1;
          EOP    <= 1'b0;
        end
        STREAM: begin
          SOP <= 1'b0;
          if (stream_done) begin
            state <= IDLE;
            VLD   <= 1'b0;
            EOP   <= 1'b0;
          end else begin
            VLD    <= 1'b1;
            EOP    <= (rd_cnt == LUT_LAST);
            rd_cnt <= rd_cnt + LUT_AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pending <= 1'b0;
    else if (start) pending <= 1'b0;
    else if (commit) pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 2'b00;
    else     err <= (err & ~{2{err_clr}}) | err_set;
  end

`ifdef LUT_LOAD_CHECKSUM_EN
  logic [7:0] sum_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_acc  <= 8'h00;
      checksum <= 8'h00;
    end else begin
      if (state == PREFETCH) sum_acc <= 8'h00;
      else if (VLD)          sum_acc <= sum_acc + packet_data;
      if (stream_done)       checksum <= sum_acc + packet_data;
    end
  end
`endif

endmodule
